// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with HI/LO result registers.
//   op 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
//   Operands are converted to magnitudes on acceptance. CALC retires one bit
//   per cycle for WIDTH cycles: shift-add for multiply, restoring
//   subtract-shift for divide. The signs are applied when HI/LO are loaded.
//   Optional build macro: MDU_FAST_MULT_EN. When it is defined, MULT/MULTU
//   skip CALC and finish with a single-cycle product. Divide is unaffected.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             valid,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Per-operation context, captured once at acceptance.
  logic             is_div_q;   // 1: divide, 0: multiply
  logic             q_neg_q;    // negate product / quotient
  logic             r_neg_q;    // negate remainder (sign of dividend)
  logic             dz_q;       // divide by zero
  logic [WIDTH-1:0] opnd_q;     // |b|: multiplicand or divisor
  logic [WIDTH-1:0] acc_hi_q;   // partial product high / partial remainder
  logic [WIDTH-1:0] acc_lo_q;   // multiplier bits / dividend -> quotient
  logic [CW-1:0]    cnt_q;

  // Operand decode. Unsigned ops keep the raw values.
  logic             op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             accept, fast_go, last_step;

  assign op_signed = ~op[0];
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];
  assign abs_a     = a_neg ? -a : a;
  assign abs_b     = b_neg ? -b : b;
  assign accept    = (state_q == IDLE) & start & ~cancel;
  assign last_step = (state_q == CALC) & ~cancel & (cnt_q == LAST);

`ifdef MDU_FAST_MULT_EN
  // Single-cycle product. Sign or zero extension to 2*WIDTH makes the low
  // 2*WIDTH bits of the product correct for both signed and unsigned ops.
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
  assign ext_a     = op_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign ext_b     = op_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign fast_prod = ext_a * ext_b;
  assign fast_go   = accept & ~op[1];
`else
  assign fast_go   = 1'b0;
`endif

  // State register.
  // NOTE: all clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; the combinational blocks use blocking (=) only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and status decode. busy covers CALC and DONE; valid is DONE only.
  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a value held and infer a latch.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    valid   = 1'b0;
    unique case (state_q)
      IDLE: if (accept) state_d = fast_go ? DONE : CALC;
      CALC: begin
        busy = 1'b1;
        if (cancel)              state_d = IDLE;
        else if (cnt_q == LAST)  state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        valid   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign div_zero = valid & dz_q;

  // One iteration step of the datapath: shift-add or restoring divide.
  logic [WIDTH-1:0] addend, div_diff, step_hi, step_lo;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic             div_ge;

  always_comb begin
    addend    = acc_lo_q[0] ? opnd_q : '0;
    mul_sum   = {1'b0, acc_hi_q} + {1'b0, addend};
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    // The difference is below the divisor whenever it is used, so it fits in WIDTH bits.
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      {step_hi, step_lo} = {mul_sum, acc_lo_q[WIDTH-1:1]};
    end
  end

  // Sign correction of the final step.
  // Divide by zero leaves the magnitude of a in the remainder. The remainder
  // takes the sign of a, so hi returns the raw a. The quotient is forced to
  // all ones.
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

  always_comb begin
    prod_raw = {step_hi, step_lo};
    prod_fix = q_neg_q ? -prod_raw : prod_raw;
    quo_fix  = dz_q ? '1 : (q_neg_q ? -step_lo : step_lo);
    rem_fix  = r_neg_q ? -step_hi : step_hi;
    res_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
  end

  // Operand capture at acceptance, then one iteration per CALC cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      is_div_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      is_div_q <= op[1];
      q_neg_q  <= a_neg ^ b_neg;
      r_neg_q  <= a_neg;
      dz_q     <= op[1] & (b == '0);
      opnd_q   <= abs_b;
      acc_hi_q <= '0;
      acc_lo_q <= abs_a;
      cnt_q    <= '0;
    end else if (state_q == CALC) begin
      acc_hi_q <= step_hi;
      acc_lo_q <= step_hi == step_hi ? step_lo : step_lo;
      acc_hi_q <= step_hi;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

  // HI/LO: an operation result on entry to DONE, or MTHI/MTLO while idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (last_step) begin
      hi <= res_hi;
      lo <= res_lo;
`ifdef MDU_FAST_MULT_EN
    end else if (fast_go) begin
      hi <= fast_prod[2*WIDTH-1:WIDTH];
      lo <= fast_prod[WIDTH-1:0];
`endif
    end else if (state_q == IDLE) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule
